// File: rtl/zone_stat_gen.sv
// Per-zone max/mean backlight statistics over a gray pixel stream; one zone band dumped at a time.
// First zone_valid 1 cycle after the band-completing pixel, then ZONE_COLS back-to-back results; no backpressure.
module zone_stat_gen #(
    parameter int ZONE_COLS = 16,
    parameter int ZONE_ROWS = 10,
    parameter int ZONE_W    = 80,
    parameter int ZONE_H    = 80,
    parameter int AVG_MUL   = 1311,
    parameter int AVG_SHIFT = 23
) (
    input  logic       i_pix_clk,
    input  logic       rst_n,
    input  logic       i_vs,
    input  logic       gray_de,
    input  logic [7:0] data_gray,
    output logic       zone_valid,
    output logic [3:0] zone_col,
    output logic [3:0] zone_row,
    output logic [7:0] zone_max,
    output logic [7:0] zone_avg,
    output logic       frame_done
);
    localparam int SX_W   = (ZONE_W > 1)    ? $clog2(ZONE_W)    : 1;
    localparam int CX_W   = (ZONE_COLS > 1) ? $clog2(ZONE_COLS) : 1;
    localparam int SY_W   = (ZONE_H > 1)    ? $clog2(ZONE_H)    : 1;
    localparam int BAND_W = $clog2(ZONE_ROWS + 1);
    localparam int SUM_W  = $clog2(ZONE_W * ZONE_H * 255 + 1);
    localparam int MUL_W  = $clog2(AVG_MUL + 1);
    localparam int PROD_W = SUM_W + MUL_W;

    typedef enum logic {ST_IDLE, ST_DUMP} state_t;

    logic              vs_q, de_q;
    logic [SX_W-1:0]   sx_q;
    logic [CX_W-1:0]   cx_q;
    logic [SY_W-1:0]   sy_q;
    logic [BAND_W-1:0] band_q;
    logic [SUM_W-1:0]  sum_q      [ZONE_COLS];
    logic [7:0]        max_q      [ZONE_COLS];
    logic [SUM_W-1:0]  shad_sum_q [ZONE_COLS];
    logic [7:0]        shad_max_q [ZONE_COLS];
    state_t            state_q;
    logic [CX_W-1:0]   idx_q;
    logic [BAND_W-1:0] row_q;
    logic              zone_valid_q, frame_done_q;
    logic [3:0]        zone_col_q, zone_row_q;
    logic [7:0]        zone_max_q, zone_avg_q;

    logic              vs_rise_d, x_last_d, band_live_d, pix_ok_d;
    logic              line_wrap_d, line_cut_d, adv_y_d, complete_d;
    logic [SUM_W-1:0]  sum_upd_d, src_sum_d;
    logic [7:0]        max_upd_d, src_max_d, avg_d;
    logic [PROD_W-1:0] prod_d, quo_d;

    assign vs_rise_d   = i_vs & ~vs_q;
    assign x_last_d    = (sx_q == SX_W'(ZONE_W - 1)) && (cx_q == CX_W'(ZONE_COLS - 1));
    assign band_live_d = band_q < BAND_W'(ZONE_ROWS);
    assign pix_ok_d    = gray_de & ~vs_rise_d & band_live_d;
    // A line ends after a full row of pixels or when gray_de drops early; the
    // fall right after a full row is not a second line end, so zero h-blank works.
    assign line_wrap_d = gray_de & ~vs_rise_d & x_last_d;
    assign line_cut_d  = ~gray_de & de_q & ~vs_rise_d & ((sx_q != '0) || (cx_q != '0));
    assign adv_y_d     = line_wrap_d | line_cut_d;
    assign complete_d  = pix_ok_d & x_last_d & (sy_q == SY_W'(ZONE_H - 1));
    assign sum_upd_d   = sum_q[cx_q] + SUM_W'(data_gray);
    assign max_upd_d   = (data_gray > max_q[cx_q]) ? data_gray : max_q[cx_q];

    always_comb begin
        src_sum_d = '0;
        src_max_d = '0;
        if (state_q == ST_DUMP) begin
            src_sum_d = shad_sum_q[idx_q];
            src_max_d = shad_max_q[idx_q];
        end else if (cx_q == '0) begin
            src_sum_d = sum_upd_d;
            src_max_d = max_upd_d;
        end else begin
            src_sum_d = sum_q[0];
            src_max_d = max_q[0];
        end
    end

    assign prod_d = PROD_W'(src_sum_d) * PROD_W'(AVG_MUL);
    assign quo_d  = prod_d >> AVG_SHIFT;
    assign avg_d  = (quo_d > PROD_W'(255)) ? 8'hFF : quo_d[7:0];

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            sx_q   <= '0;
            cx_q   <= '0;
            sy_q   <= '0;
            band_q <= '0;
        end else begin
            vs_q <= i_vs;
            de_q <= gray_de;
            if (vs_rise_d) begin
                sx_q   <= '0;
                cx_q   <= '0;
                sy_q   <= '0;
                band_q <= '0;
            end else begin
                if (gray_de) begin
                    if (sx_q == SX_W'(ZONE_W - 1)) begin
                        sx_q <= '0;
                        cx_q <= (cx_q == CX_W'(ZONE_COLS - 1)) ? '0 : cx_q + 1'b1;
                    end else begin
                        sx_q <= sx_q + 1'b1;
                    end
                end else if (line_cut_d) begin
                    sx_q <= '0;
                    cx_q <= '0;
                end
                if (adv_y_d) begin
                    if (sy_q == SY_W'(ZONE_H - 1)) begin
                        sy_q <= '0;
                        if (band_live_d) band_q <= band_q + 1'b1;
                    end else begin
                        sy_q <= sy_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < ZONE_COLS; c++) begin
                sum_q[c]      <= '0;
                max_q[c]      <= '0;
                shad_sum_q[c] <= '0;
                shad_max_q[c] <= '0;
            end
        end else begin
            if (vs_rise_d || complete_d) begin
                for (int c = 0; c < ZONE_COLS; c++) begin
                    sum_q[c] <= '0;
                    max_q[c] <= '0;
                end
            end else if (pix_ok_d) begin
                sum_q[cx_q] <= sum_upd_d;
                max_q[cx_q] <= max_upd_d;
            end
            // Shadow captures the band including the completing pixel itself.
            if (complete_d) begin
                for (int c = 0; c < ZONE_COLS; c++) begin
                    shad_sum_q[c] <= (CX_W'(c) == cx_q) ? sum_upd_d : sum_q[c];
                    shad_max_q[c] <= (CX_W'(c) == cx_q) ? max_upd_d : max_q[c];
                end
            end
        end
    end

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            row_q        <= '0;
            zone_valid_q <= 1'b0;
            zone_col_q   <= '0;
            zone_row_q   <= '0;
            zone_max_q   <= '0;
            zone_avg_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= zone_valid_q && (zone_col_q == 4'(ZONE_COLS - 1))
                            && (zone_row_q == 4'(ZONE_ROWS - 1));
            case (state_q)
                ST_IDLE: begin
                    zone_valid_q <= 1'b0;
                    // Zone 0 goes out straight from the live registers so the first result lands 1 cycle after completion.
                    if (complete_d) begin
                        zone_valid_q <= 1'b1;
                        zone_col_q   <= '0;
                        zone_row_q   <= 4'(band_q);
                        zone_max_q   <= src_max_d;
                        zone_avg_q   <= avg_d;
                        row_q        <= band_q;
                        idx_q        <= CX_W'(1);
                        if (ZONE_COLS > 1) state_q <= ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    zone_valid_q <= 1'b1;
                    zone_col_q   <= 4'(idx_q);
                    zone_row_q   <= 4'(row_q);
                    zone_max_q   <= src_max_d;
                    zone_avg_q   <= avg_d;
                    if (idx_q == CX_W'(ZONE_COLS - 1)) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign zone_valid = zone_valid_q;
    assign zone_col   = zone_col_q;
    assign zone_row   = zone_row_q;
    assign zone_max   = zone_max_q;
    assign zone_avg   = zone_avg_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_zone_stat_gen.sv
// Directed bench for zone_stat_gen on a reduced 4x3 grid of 5x4-pixel zones (20x12 frame).
// Reciprocal 205>>12 for 20-pixel zones: 128->128, 255->255, 64->64, 77->77, lone 255->12, lone 50->2, lone 200->10.
module tb_zone_stat_gen;
    localparam int C  = 4;
    localparam int R  = 3;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int LW = C * W;
    localparam int NL = R * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_vs = 1'b0;
    logic       gray_de = 1'b0;
    logic [7:0] data_gray = 8'd0;
    logic       zone_valid, frame_done;
    logic [3:0] zone_col, zone_row;
    logic [7:0] zone_max, zone_avg;

    zone_stat_gen #(
        .ZONE_COLS(C), .ZONE_ROWS(R), .ZONE_W(W), .ZONE_H(H),
        .AVG_MUL(205), .AVG_SHIFT(12)
    ) dut (
        .i_pix_clk(clk), .rst_n(rst_n), .i_vs(i_vs), .gray_de(gray_de),
        .data_gray(data_gray), .zone_valid(zone_valid), .zone_col(zone_col),
        .zone_row(zone_row), .zone_max(zone_max), .zone_avg(zone_avg),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         got_cnt  [0:R-1][0:C-1];
    int         base_cnt [0:R-1][0:C-1];
    logic [7:0] got_max  [0:R-1][0:C-1];
    logic [7:0] got_avg  [0:R-1][0:C-1];
    int         first_cyc [0:R-1];
    int         compl_cyc [0:R-1];
    int         done_cnt = 0, done_cyc = 0, bad_idx = 0;
    int         base_done = 0, base_bad = 0;
    logic [7:0] img [0:NL-1][0:LW-1];
    int         tests = 0, fails = 0;

    initial begin
        for (int r = 0; r < R; r++) begin
            first_cyc[r] = 0;
            compl_cyc[r] = 0;
            for (int c = 0; c < C; c++) got_cnt[r][c] = 0;
        end
    end

    always @(negedge clk) begin
        if (zone_valid === 1'b1) begin
            if (zone_row < R && zone_col < C) begin
                got_cnt[zone_row][zone_col] = got_cnt[zone_row][zone_col] + 1;
                got_max[zone_row][zone_col] = zone_max;
                got_avg[zone_row][zone_col] = zone_avg;
                if (zone_col == 0) first_cyc[zone_row] = cyc;
            end else begin
                bad_idx = bad_idx + 1;
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int l = 0; l < NL; l++)
            for (int x = 0; x < LW; x++) img[l][x] = v;
    endtask

    task automatic snap();
        base_cnt  = got_cnt;
        base_done = done_cnt;
        base_bad  = bad_idx;
    endtask

    task automatic send_frame(input int nlines, input int hblank, input int vblank);
        i_vs = 1'b1;
        tick();
        tick();
        i_vs = 1'b0;
        tick();
        for (int l = 0; l < nlines; l++) begin
            for (int x = 0; x < LW; x++) begin
                gray_de   = 1'b1;
                data_gray = img[l][x];
                if (x == LW - 1 && (l % H) == H - 1) compl_cyc[l / H] = cyc;
                tick();
            end
            if (l != nlines - 1) begin
                gray_de   = 1'b0;
                data_gray = 8'd0;
                repeat (hblank) tick();
            end
        end
        gray_de   = 1'b0;
        data_gray = 8'd0;
        repeat (vblank) tick();
    endtask

    task automatic test_reset();
        tick();
        rst_n = 1'b0;
        #1;
        tests++; if (zone_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", zone_valid); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", frame_done); end
        tests++; if (zone_col !== 4'd0) begin fails++; $display("FAIL reset_col: got %0d expected 0", zone_col); end
        tests++; if (zone_row !== 4'd0) begin fails++; $display("FAIL reset_row: got %0d expected 0", zone_row); end
        tests++; if (zone_max !== 8'd0) begin fails++; $display("FAIL reset_max: got %0d expected 0", zone_max); end
        tests++; if (zone_avg !== 8'd0) begin fails++; $display("FAIL reset_avg: got %0d expected 0", zone_avg); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        tests++; if (zone_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %b expected 0", zone_valid); end
    endtask

    task automatic test_flat();
        fill(8'd128);
        snap();
        send_frame(NL, 3, C + 4);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                tests++; if (got_cnt[r][c] - base_cnt[r][c] != 1) begin fails++; $display("FAIL flat_cnt(%0d,%0d): got %0d expected 1", c, r, got_cnt[r][c] - base_cnt[r][c]); end
                tests++; if (got_max[r][c] !== 8'd128) begin fails++; $display("FAIL flat_max(%0d,%0d): got %0d expected 128", c, r, got_max[r][c]); end
                tests++; if (got_avg[r][c] !== 8'd128) begin fails++; $display("FAIL flat_avg(%0d,%0d): got %0d expected 128", c, r, got_avg[r][c]); end
            end
            tests++; if (first_cyc[r] != compl_cyc[r] + 1) begin fails++; $display("FAIL flat_latency band %0d: got cycle %0d expected %0d", r, first_cyc[r], compl_cyc[r] + 1); end
        end
        tests++; if (done_cnt - base_done != 1) begin fails++; $display("FAIL flat_done_count: got %0d expected 1", done_cnt - base_done); end
        tests++; if (done_cyc != first_cyc[R-1] + C) begin fails++; $display("FAIL flat_done_cycle: got %0d expected %0d", done_cyc, first_cyc[R-1] + C); end
        tests++; if (bad_idx != base_bad) begin fails++; $display("FAIL flat_bad_index: got %0d expected 0", bad_idx - base_bad); end
    endtask

    task automatic test_hot_pixel();
        logic [7:0] em, ea;
        fill(8'd0);
        img[3][6] = 8'd255;
        snap();
        send_frame(NL, 3, C + 4);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                em = (r == 0 && c == 1) ? 8'd255 : 8'd0;
                ea = (r == 0 && c == 1) ? 8'd12 : 8'd0;
                tests++; if (got_cnt[r][c] - base_cnt[r][c] != 1) begin fails++; $display("FAIL hot_cnt(%0d,%0d): got %0d expected 1", c, r, got_cnt[r][c] - base_cnt[r][c]); end
                tests++; if (got_max[r][c] !== em) begin fails++; $display("FAIL hot_max(%0d,%0d): got %0d expected %0d", c, r, got_max[r][c], em); end
                tests++; if (got_avg[r][c] !== ea) begin fails++; $display("FAIL hot_avg(%0d,%0d): got %0d expected %0d", c, r, got_avg[r][c], ea); end
            end
        end
    endtask

    task automatic test_full_white();
        fill(8'd255);
        snap();
        send_frame(NL, 2, C + 4);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                tests++; if (got_max[r][c] !== 8'd255) begin fails++; $display("FAIL white_max(%0d,%0d): got %0d expected 255", c, r, got_max[r][c]); end
                tests++; if (got_avg[r][c] !== 8'd255) begin fails++; $display("FAIL white_avg(%0d,%0d): got %0d expected 255", c, r, got_avg[r][c]); end
            end
        end
        tests++; if (done_cnt - base_done != 1) begin fails++; $display("FAIL white_done_count: got %0d expected 1", done_cnt - base_done); end
    endtask

    task automatic test_zero_hblank();
        fill(8'd0);
        img[H-1][LW-1] = 8'd50;
        img[H][0]      = 8'd200;
        snap();
        send_frame(NL, 0, C + 4);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                tests++; if (got_cnt[r][c] - base_cnt[r][c] != 1) begin fails++; $display("FAIL zhb_cnt(%0d,%0d): got %0d expected 1", c, r, got_cnt[r][c] - base_cnt[r][c]); end
            end
        tests++; if (got_max[0][0] !== 8'd0) begin fails++; $display("FAIL zhb_max(0,0): got %0d expected 0", got_max[0][0]); end
        tests++; if (got_max[0][C-1] !== 8'd50) begin fails++; $display("FAIL zhb_max(3,0): got %0d expected 50", got_max[0][C-1]); end
        tests++; if (got_avg[0][C-1] !== 8'd2) begin fails++; $display("FAIL zhb_avg(3,0): got %0d expected 2", got_avg[0][C-1]); end
        tests++; if (got_max[1][0] !== 8'd200) begin fails++; $display("FAIL zhb_max(0,1): got %0d expected 200", got_max[1][0]); end
        tests++; if (got_avg[1][0] !== 8'd10) begin fails++; $display("FAIL zhb_avg(0,1): got %0d expected 10", got_avg[1][0]); end
        tests++; if (done_cnt - base_done != 1) begin fails++; $display("FAIL zhb_done_count: got %0d expected 1", done_cnt - base_done); end
    endtask

    task automatic test_mid_frame_sync();
        fill(8'd200);
        snap();
        send_frame(H + 2, 3, C + 4);
        for (int c = 0; c < C; c++) begin
            tests++; if (got_cnt[0][c] - base_cnt[0][c] != 1) begin fails++; $display("FAIL sync_band0_cnt(%0d): got %0d expected 1", c, got_cnt[0][c] - base_cnt[0][c]); end
            tests++; if (got_cnt[1][c] - base_cnt[1][c] != 0) begin fails++; $display("FAIL sync_band1_cnt(%0d): got %0d expected 0", c, got_cnt[1][c] - base_cnt[1][c]); end
        end
        tests++; if (done_cnt - base_done != 0) begin fails++; $display("FAIL sync_abort_done: got %0d expected 0", done_cnt - base_done); end
        fill(8'd64);
        snap();
        send_frame(NL, 3, C + 4);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                tests++; if (got_cnt[r][c] - base_cnt[r][c] != 1) begin fails++; $display("FAIL sync_cnt(%0d,%0d): got %0d expected 1", c, r, got_cnt[r][c] - base_cnt[r][c]); end
                tests++; if (got_max[r][c] !== 8'd64) begin fails++; $display("FAIL sync_max(%0d,%0d): got %0d expected 64", c, r, got_max[r][c]); end
                tests++; if (got_avg[r][c] !== 8'd64) begin fails++; $display("FAIL sync_avg(%0d,%0d): got %0d expected 64", c, r, got_avg[r][c]); end
            end
        tests++; if (done_cnt - base_done != 1) begin fails++; $display("FAIL sync_done_count: got %0d expected 1", done_cnt - base_done); end
    endtask

    task automatic test_reset_during_dump();
        bit found = 1'b0;
        fill(8'd100);
        snap();
        send_frame(NL, 3, 0);
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (zone_valid === 1'b1 && zone_row == 4'(R - 1) && zone_col == 4'd2) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL rst_dump_wait: got no zone (2,2) within 40 cycles, expected one"); end
        rst_n = 1'b0;
        #1;
        tests++; if (zone_valid !== 1'b0) begin fails++; $display("FAIL rst_dump_valid: got %b expected 0", zone_valid); end
        tests++; if (zone_max !== 8'd0) begin fails++; $display("FAIL rst_dump_max: got %0d expected 0", zone_max); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        tests++; if (got_cnt[R-1][C-1] - base_cnt[R-1][C-1] != 0) begin fails++; $display("FAIL rst_dump_tail: got %0d results expected 0", got_cnt[R-1][C-1] - base_cnt[R-1][C-1]); end
        tests++; if (done_cnt - base_done != 0) begin fails++; $display("FAIL rst_dump_done: got %0d expected 0", done_cnt - base_done); end
        fill(8'd77);
        snap();
        send_frame(NL, 3, C + 4);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                tests++; if (got_cnt[r][c] - base_cnt[r][c] != 1) begin fails++; $display("FAIL rst_next_cnt(%0d,%0d): got %0d expected 1", c, r, got_cnt[r][c] - base_cnt[r][c]); end
                tests++; if (got_max[r][c] !== 8'd77) begin fails++; $display("FAIL rst_next_max(%0d,%0d): got %0d expected 77", c, r, got_max[r][c]); end
                tests++; if (got_avg[r][c] !== 8'd77) begin fails++; $display("FAIL rst_next_avg(%0d,%0d): got %0d expected 77", c, r, got_avg[r][c]); end
            end
        tests++; if (done_cnt - base_done != 1) begin fails++; $display("FAIL rst_next_done: got %0d expected 1", done_cnt - base_done); end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_hot_pixel();
        test_full_white();
        test_zero_hblank();
        test_mid_frame_sync();
        test_reset_during_dump();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
